// File: rtl/cc_light_bar_if.sv
// rtl/cc_light_bar_if.sv - play controls and bar outputs for the light-bar position counter
interface cc_light_bar_if #(
    parameter int N = 8
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic          active;
    logic          over;
    logic          up;
    logic          down;
    logic [N-1:0]  lights;
    logic [PW-1:0] pos;
    logic          at_top;
    logic          at_bottom;
    logic          top_hit;
    logic [1:0]    state;

    modport master (
        output active, over, up, down,
        input  lights, pos, at_top, at_bottom, top_hit, state
    );

    modport slave (
        input  active, over, up, down,
        output lights, pos, at_top, at_bottom, top_hit, state
    );
endinterface

// File: rtl/cc_light_bar.sv
// rtl/cc_light_bar.sv - stepped one-hot light bar; CC_LIGHT_BAR_GRAVITY_EN makes idle ticks fall toward 0
module cc_light_bar #(
    parameter int N     = 8,
    parameter int DIV_W = 7,
    parameter int START = 0
) (
    input  logic           clk,
    input  logic           reset,
    cc_light_bar_if.slave  bus
);
    localparam int            PW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] TOP     = PW'(N - 1);
    localparam logic [PW-1:0] START_P = PW'(START);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2,
        BAD    = 2'd3
    } state_t;

    state_t           state_q, state_nxt;
    logic [PW-1:0]    pos_q, pos_nxt;
    logic [DIV_W-1:0] div_q, div_nxt;
    logic             hit_q, hit_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pos_q   <= START_P;
            div_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pos_q   <= pos_nxt;
            div_q   <= div_nxt;
            hit_q   <= hit_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        pos_nxt   = pos_q;
        div_nxt   = div_q;
        hit_nxt   = 1'b0;
        // Dropping active returns to the idle position immediately, whatever else is requested.
        if (!bus.active) begin
            state_nxt = IDLE;
            pos_nxt   = START_P;
            div_nxt   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    pos_nxt   = START_P;
                    div_nxt   = '0;
                    state_nxt = bus.over ? FROZEN : RUN;
                end
                RUN: begin
                    if (bus.over) begin
                        state_nxt = FROZEN;
                    end else begin
                        div_nxt = div_q + 1'b1;
                        // A divider value of zero is the step tick; up/down are ignored otherwise.
                        if (div_q == '0) begin
                            if (bus.up && !bus.down) begin
                                if (pos_q != TOP) pos_nxt = pos_q + 1'b1;
                            end else if (bus.down && !bus.up) begin
                                if (pos_q != '0) pos_nxt = pos_q - 1'b1;
                            end
`ifdef CC_LIGHT_BAR_GRAVITY_EN
                            else if (!bus.up && !bus.down) begin
                                if (pos_q != '0) pos_nxt = pos_q - 1'b1;
                            end
`endif
                            hit_nxt = (pos_nxt == TOP) && (pos_q != TOP);
                        end
                    end
                end
                FROZEN: begin
                    if (!bus.over) state_nxt = RUN;
                end
                default: begin
                    state_nxt = IDLE;
                    pos_nxt   = START_P;
                    div_nxt   = '0;
                end
            endcase
        end
    end

    assign bus.lights    = {{(N-1){1'b0}}, 1'b1} << pos_q;
    assign bus.pos       = pos_q;
    assign bus.at_top    = (pos_q == TOP);
    assign bus.at_bottom = (pos_q == '0);
    assign bus.top_hit   = hit_q;
    assign bus.state     = state_q;
endmodule
